// File: rtl/mxn_bit_and_nand_nor.sv
// mxn_bit_and_nand_nor: registered SETS-lane bitwise AND / NAND / NOR unit.
// Lanes of WIDTH bits do not interact with each other. Results load on a clock
// edge with in_valid=1 and hold otherwise. out_valid marks the edge that loaded them.
// Optional macro MXN_LOGIC_ZERO_FLAG_EN adds per-lane all-zero flags for each result.
module mxn_bit_and_nand_nor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SETS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [SETS*WIDTH-1:0]   in1_packed,
  input  logic [SETS*WIDTH-1:0]   in2_packed,
  output logic [SETS*WIDTH-1:0]   and_out_packed,
  output logic [SETS*WIDTH-1:0]   nand_out_packed,
  output logic [SETS*WIDTH-1:0]   nor_out_packed,
  output logic                    out_valid
`ifdef MXN_LOGIC_ZERO_FLAG_EN
  ,
  output logic [SETS-1:0]         and_zero,
  output logic [SETS-1:0]         nand_zero,
  output logic [SETS-1:0]         nor_zero
`endif
);

  // Shared valid strobe: high only after an edge that captured operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  for (genvar i = 0; i < SETS; i++) begin : g_lane
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] nand_d;
    logic [WIDTH-1:0] nor_d;
    logic [WIDTH-1:0] and_q;
    logic [WIDTH-1:0] nand_q;
    logic [WIDTH-1:0] nor_q;

    assign a = in1_packed[i*WIDTH +: WIDTH];
    assign b = in2_packed[i*WIDTH +: WIDTH];

    // Per-lane bitwise results; no interaction between bits or lanes.
    always_comb begin
      and_d  = a & b;
      nand_d = ~(a & b);
      nor_d  = ~(a | b);
    end

    // Lane result registers: clear on reset, load on in_valid, else hold.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        and_q  <= '0;
        nand_q <= '0;
        nor_q  <= '0;
      end else if (in_valid) begin
        and_q  <= and_d;
        nand_q <= nand_d;
        nor_q  <= nor_d;
      end
    end

    assign and_out_packed[i*WIDTH +: WIDTH]  = and_q;
    assign nand_out_packed[i*WIDTH +: WIDTH] = nand_q;
    assign nor_out_packed[i*WIDTH +: WIDTH]  = nor_q;

`ifdef MXN_LOGIC_ZERO_FLAG_EN
    logic and_zq;
    logic nand_zq;
    logic nor_zq;

    // Zero flags follow the same capture rule as the lane results.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        and_zq  <= 1'b0;
        nand_zq <= 1'b0;
        nor_zq  <= 1'b0;
      end else if (in_valid) begin
        and_zq  <= (and_d == '0);
        nand_zq <= (nand_d == '0);
        nor_zq  <= (nor_d == '0);
      end
    end

    assign and_zero[i]  = and_zq;
    assign nand_zero[i] = nand_zq;
    assign nor_zero[i]  = nor_zq;
`endif
  end

endmodule

// File: tb/tb_mxn_bit_and_nand_nor.sv
// Directed self-checking bench for mxn_bit_and_nand_nor (WIDTH=4, SETS=2).
module tb_mxn_bit_and_nand_nor;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in1_packed;
  logic [7:0] in2_packed;
  logic [7:0] and_out_packed;
  logic [7:0] nand_out_packed;
  logic [7:0] nor_out_packed;
  logic       out_valid;
`ifdef MXN_LOGIC_ZERO_FLAG_EN
  logic [1:0] and_zero;
  logic [1:0] nand_zero;
  logic [1:0] nor_zero;
`endif

  int passed = 0;
  int total  = 0;

  mxn_bit_and_nand_nor #(.WIDTH(4), .SETS(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in1_packed      (in1_packed),
    .in2_packed      (in2_packed),
    .and_out_packed  (and_out_packed),
    .nand_out_packed (nand_out_packed),
    .nor_out_packed  (nor_out_packed),
    .out_valid       (out_valid)
`ifdef MXN_LOGIC_ZERO_FLAG_EN
    ,
    .and_zero        (and_zero),
    .nand_zero       (nand_zero),
    .nor_zero        (nor_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] ea, input logic [7:0] en,
                           input logic [7:0] eo, input logic ev);
    check({tag, "_and"},   {24'h0, and_out_packed},  {24'h0, ea});
    check({tag, "_nand"},  {24'h0, nand_out_packed}, {24'h0, en});
    check({tag, "_nor"},   {24'h0, nor_out_packed},  {24'h0, eo});
    check({tag, "_valid"}, {31'h0, out_valid},       {31'h0, ev});
  endtask

  initial begin
    logic [3:0] a, b, c, d;
    logic [7:0] x, y;

    rst = 1'b1;
    in_valid = 1'b0;
    in1_packed = '0;
    in2_packed = '0;
    #12;
    check_all("reset_init", 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector A5 / 3C.
    in1_packed = 8'hA5; in2_packed = 8'h3C; in_valid = 1'b1;
    step();
    check_all("vec_a5_3c", 8'h24, 8'hDB, 8'h42, 1'b1);

    // Hold: three idle edges with changing operands.
    in_valid = 1'b0;
    in1_packed = 8'hFF; in2_packed = 8'h00;
    step();
    check_all("hold1", 8'h24, 8'hDB, 8'h42, 1'b0);
    in1_packed = 8'h12; in2_packed = 8'h34;
    step();
    check_all("hold2", 8'h24, 8'hDB, 8'h42, 1'b0);
    in1_packed = 8'h00; in2_packed = 8'hFF;
    step();
    check_all("hold3", 8'h24, 8'hDB, 8'h42, 1'b0);

    // Boundary: all-ones and all-zeros operands.
    in1_packed = 8'hFF; in2_packed = 8'hFF; in_valid = 1'b1;
    step();
    check_all("ones", 8'hFF, 8'h00, 8'h00, 1'b1);
    in1_packed = 8'h00; in2_packed = 8'h00;
    step();
    check_all("zeros", 8'h00, 8'hFF, 8'hFF, 1'b1);

    // Asynchronous reset between edges, held across a valid edge.
    in1_packed = 8'hC3; in2_packed = 8'h5A;
    #2 rst = 1'b1;
    #1 check_all("async_rst", 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    check_all("rst_held", 8'h00, 8'h00, 8'h00, 1'b0);
    #3 rst = 1'b0;
    in_valid = 1'b0;
    step();
    check_all("post_rst_idle", 8'h00, 8'h00, 8'h00, 1'b0);
    in_valid = 1'b1;
    step();
    check_all("post_rst_first", 8'h42, 8'hBD, 8'h24, 1'b1);

    // Exhaustive lane-0 sweep with lane 1 stepped independently.
    for (int i = 0; i < 256; i++) begin
      a = i[3:0];
      b = i[7:4];
      c = 4'(i * 7 + 3);
      d = 4'(i * 11 + 5) ^ i[7:4];
      x = {c, a};
      y = {d, b};
      in1_packed = x; in2_packed = y; in_valid = 1'b1;
      step();
      check_all("sweep", x & y, ~(x & y), ~(x | y), 1'b1);
    end

    // Reset pulsed for half a cycle mid-stream.
    in1_packed = 8'h96; in2_packed = 8'hF0;
    step();
    check_all("stream", 8'h90, 8'h6F, 8'h09, 1'b1);
    in1_packed = 8'h3C; in2_packed = 8'h0F;
    #2 rst = 1'b1;
    #1 check_all("mid_rst", 8'h00, 8'h00, 8'h00, 1'b0);
    #4 rst = 1'b0;
    step();
    check_all("after_mid_rst", 8'h0C, 8'hF3, 8'hC0, 1'b1);

`ifdef MXN_LOGIC_ZERO_FLAG_EN
    in1_packed = 8'hF0; in2_packed = 8'h0F;
    step();
    check_all("zf_vec", 8'h00, 8'hFF, 8'h00, 1'b1);
    check("and_zero",  {30'h0, and_zero},  32'h3);
    check("nand_zero", {30'h0, nand_zero}, 32'h0);
    check("nor_zero",  {30'h0, nor_zero},  32'h3);
    in_valid = 1'b0;
    in1_packed = 8'hFF; in2_packed = 8'hFF;
    step();
    check("and_zero_hold", {30'h0, and_zero}, 32'h3);
    in_valid = 1'b1;
    in1_packed = 8'h0F; in2_packed = 8'h0F;
    step();
    check("and_zero_mixed",  {30'h0, and_zero},  32'h2);
    check("nand_zero_mixed", {30'h0, nand_zero}, 32'h1);
    check("nor_zero_mixed",  {30'h0, nor_zero},  32'h1);
    #2 rst = 1'b1;
    #1 check("zero_rst", {26'h0, and_zero, nand_zero, nor_zero}, 32'h0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
